// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding req/rvalid
// handshake to instruction memory and presents ir/pc1/if_valid/flush to decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_8000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic [31:0] pc1,
    output logic        flush,
    output logic        if_valid,
    output logic        fetch_fault
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_FAULT = 3'd5;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    logic [2:0]  state_r,     state_s;
    logic [31:0] pc_r,        pc_s;
    logic [31:0] ir_r,        ir_s;
    logic [31:0] pc1_r,       pc1_s;
    logic        if_valid_r,  if_valid_s;
    logic        flush_r,     flush_s;
    logic        fault_r,     fault_s;
    logic        req_r,       req_s;
    logic [31:0] addr_r,      addr_s;
    logic [31:0] hold_insn_r, hold_insn_s;
    logic [31:0] hold_pc_r,   hold_pc_s;

    // Next-state, datapath and output computation for the fetch FSM
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        pc1_s       = pc1_r;
        flush_s     = 1'b0;
        fault_s     = fault_r;
        hold_insn_s = hold_insn_r;
        hold_pc_s   = hold_pc_r;

        // A non-stalled edge that delivers nothing leaves a bubble, never a repeat
        if (stall) begin
            ir_s       = ir_r;
            if_valid_s = if_valid_r;
        end else begin
            ir_s       = NOP_INSN;
            if_valid_s = 1'b0;
        end

        if (state_r == ST_FAULT) begin
            ir_s       = NOP_INSN;
            if_valid_s = 1'b0;
        end else if (redirect) begin
            flush_s     = 1'b1;
            ir_s        = NOP_INSN;
            if_valid_s  = 1'b0;
            hold_insn_s = NOP_INSN;
            hold_pc_s   = 32'h0000_0000;
            if (is_misaligned(redirect_pc)) begin
                fault_s = 1'b1;
                state_s = ST_FAULT;
            end else begin
                pc_s = redirect_pc;
                // A request launched in ISSUE or still pending must be drained first
                case (state_r)
                    ST_ISSUE: state_s = ST_DRAIN;
                    ST_WAIT:  state_s = imem_rvalid ? ST_ISSUE : ST_DRAIN;
                    ST_DRAIN: state_s = imem_rvalid ? ST_ISSUE : ST_DRAIN;
                    default:  state_s = ST_ISSUE;
                endcase
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_ISSUE;
                end
                ST_ISSUE: begin
                    state_s = ST_WAIT;
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        pc_s = pc_r + 32'd4;
                        if (stall) begin
                            hold_insn_s = imem_rdata;
                            hold_pc_s   = pc_r;
                            state_s     = ST_HOLD;
                        end else begin
                            ir_s       = imem_rdata;
                            pc1_s      = pc_r;
                            if_valid_s = 1'b1;
                            state_s    = ST_ISSUE;
                        end
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        ir_s        = hold_insn_r;
                        pc1_s       = hold_pc_r;
                        if_valid_s  = 1'b1;
                        hold_insn_s = NOP_INSN;
                        state_s     = ST_ISSUE;
                    end else begin
                        state_s = ST_HOLD;
                    end
                end
                ST_DRAIN: begin
                    if (imem_rvalid) begin
                        state_s = ST_ISSUE;
                    end else begin
                        state_s = ST_DRAIN;
                    end
                end
                default: begin
                    ir_s       = NOP_INSN;
                    if_valid_s = 1'b0;
                    state_s    = ST_IDLE;
                end
            endcase
        end

        req_s  = (state_s == ST_ISSUE);
        addr_s = pc_s;
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            pc_r        <= RESET_PC;
            ir_r        <= NOP_INSN;
            pc1_r       <= RESET_PC;
            if_valid_r  <= 1'b0;
            flush_r     <= 1'b0;
            fault_r     <= 1'b0;
            req_r       <= 1'b0;
            addr_r      <= RESET_PC;
            hold_insn_r <= NOP_INSN;
            hold_pc_r   <= 32'h0000_0000;
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            ir_r        <= ir_s;
            pc1_r       <= pc1_s;
            if_valid_r  <= if_valid_s;
            flush_r     <= flush_s;
            fault_r     <= fault_s;
            req_r       <= req_s;
            addr_r      <= addr_s;
            hold_insn_r <= hold_insn_s;
            hold_pc_r   <= hold_pc_s;
        end
    end

    assign imem_req    = req_r;
    assign imem_addr   = addr_r;
    assign ir          = ir_r;
    assign pc1         = pc1_r;
    assign flush       = flush_r;
    assign if_valid    = if_valid_r;
    assign fetch_fault = fault_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized stall,
// redirect and memory latency, checked against a transaction-level PC model.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_8000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n, stall, redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] ir, pc1;
    logic        flush, if_valid, fetch_fault;

    fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSN(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .ir(ir), .pc1(pc1),
        .flush(flush), .if_valid(if_valid), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // memory model: one pending response, delivered after pend_dly extra cycles
    bit          pend;
    logic [31:0] pend_addr;
    int          pend_dly;
    int          lat_lo, lat_hi;

    // program-order model: next address to fetch, next PC decode should see
    logic [31:0] exp_fetch, exp_deliver;
    bit          fault;
    logic [31:0] p_ir, p_pc1;
    logic        p_valid;
    int          n_deliv = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'h0000_8000: return 32'h0050_0093;
            32'h0000_8004: return 32'h00A0_0113;
            32'h0000_8008: return 32'hDEAD_BEEF;
            default:       return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
        endcase
    endfunction

    task automatic mem_tick();
        if (pend && pend_dly == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memf(pend_addr);
            pend        = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (pend) pend_dly--;
        end
    endtask

    task automatic model_reset();
        exp_fetch   = RESET_PC;
        exp_deliver = RESET_PC;
        fault       = 1'b0;
        p_ir        = NOP;
        p_pc1       = RESET_PC;
        p_valid     = 1'b0;
    endtask

    // One clock with the given stall/redirect; checks every output against the model
    task automatic step(input logic s, input logic r, input logic [31:0] t);
        bit was_fault;
        stall       = s;
        redirect    = r;
        redirect_pc = t;
        if (imem_req) begin
            chk_eq("req_while_outstanding", {31'd0, pend}, 32'd0);
            chk_eq("fetch_addr", imem_addr, exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
        end
        mem_tick();
        if (imem_req) begin
            pend      = 1'b1;
            pend_addr = imem_addr;
            pend_dly  = $urandom_range(lat_hi, lat_lo);
        end
        @(posedge clk);
        #1;
        was_fault = fault;
        if (r && !fault) begin
            if (t[1:0] != 2'b00) begin
                fault = 1'b1;
            end else begin
                exp_fetch   = t;
                exp_deliver = t;
            end
        end
        chk_eq("flush", {31'd0, flush}, {31'd0, (r && !was_fault)});
        chk_eq("fetch_fault", {31'd0, fetch_fault}, {31'd0, fault});
        if (fault) begin
            chk_eq("fault_req", {31'd0, imem_req}, 32'd0);
            chk_eq("fault_ir", ir, NOP);
            chk_eq("fault_valid", {31'd0, if_valid}, 32'd0);
        end else if (r) begin
            chk_eq("redirect_ir", ir, NOP);
            chk_eq("redirect_valid", {31'd0, if_valid}, 32'd0);
        end else if (s) begin
            chk_eq("stall_ir", ir, p_ir);
            chk_eq("stall_pc1", pc1, p_pc1);
            chk_eq("stall_valid", {31'd0, if_valid}, {31'd0, p_valid});
        end else if (if_valid) begin
            chk_eq("deliver_pc1", pc1, exp_deliver);
            chk_eq("deliver_ir", ir, memf(exp_deliver));
            exp_deliver = exp_deliver + 32'd4;
            n_deliv++;
        end else begin
            chk_eq("bubble_ir", ir, NOP);
        end
        p_ir    = ir;
        p_pc1   = pc1;
        p_valid = if_valid;
    endtask

    // Hold reset for n edges, check reset values, then release with any late
    // memory response landing in the first post-reset (IDLE) cycle
    task automatic do_reset(input int n);
        rst_n    = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        repeat (n) begin
            mem_tick();
            @(posedge clk);
            #1;
        end
        chk_eq("rst_ir", ir, NOP);
        chk_eq("rst_pc1", pc1, RESET_PC);
        chk_eq("rst_flush", {31'd0, flush}, 32'd0);
        chk_eq("rst_valid", {31'd0, if_valid}, 32'd0);
        chk_eq("rst_req", {31'd0, imem_req}, 32'd0);
        chk_eq("rst_addr", imem_addr, RESET_PC);
        chk_eq("rst_fault", {31'd0, fetch_fault}, 32'd0);
        rst_n = 1'b1;
        if (pend) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hBAAD_F00D;
            pend        = 1'b0;
        end else begin
            imem_rvalid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk_eq("idle_ir", ir, NOP);
        chk_eq("idle_valid", {31'd0, if_valid}, 32'd0);
        model_reset();
    endtask

    initial begin
        logic [31:0] tgt;
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        imem_rvalid = 1'b0; imem_rdata = 32'd0;
        pend = 1'b0; pend_addr = 32'd0; pend_dly = 0;
        lat_lo = 0; lat_hi = 0;
        model_reset();
        do_reset(3);

        // basic fetch with 1-cycle memory
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        chk_eq("t1_ir", ir, 32'h0050_0093);
        chk_eq("t1_pc1", pc1, 32'h0000_8000);
        chk_eq("t1_valid", {31'd0, if_valid}, 32'd1);

        // stall across the response of 8004
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        chk_eq("t2_frozen_ir", ir, 32'h0050_0093);
        step(1'b0, 1'b0, 32'd0);
        chk_eq("t2_ir", ir, 32'h00A0_0113);
        chk_eq("t2_pc1", pc1, 32'h0000_8004);

        // redirect while waiting; stale DEADBEEF arrives two cycles later
        lat_lo = 2; lat_hi = 2;
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 32'h0000_8100);
        chk_eq("t3_flush", {31'd0, flush}, 32'd1);
        lat_lo = 0; lat_hi = 0;
        step(1'b0, 1'b0, 32'd0);
        chk_eq("t3_flush_once", {31'd0, flush}, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        chk_eq("t3_no_stale", {31'd0, (ir == 32'hDEAD_BEEF)}, 32'd0);
        chk_eq("t3_req", {31'd0, imem_req}, 32'd1);
        chk_eq("t3_addr", imem_addr, 32'h0000_8100);

        // redirect, stall and rvalid in the same cycle
        step(1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'h0000_8200);
        chk_eq("t4_ir", ir, NOP);
        chk_eq("t4_addr", imem_addr, 32'h0000_8200);
        step(1'b0, 1'b0, 32'd0);

        // misaligned redirect is terminal until reset
        step(1'b0, 1'b1, 32'h0000_8102);
        chk_eq("t5_fault", {31'd0, fetch_fault}, 32'd1);
        for (int i = 0; i < 20; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'h0000_8300);
        do_reset(2);
        chk_eq("t5_restart", imem_addr, RESET_PC);
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);

        // reset during WAIT with the response arriving at reset release
        do_reset(1);
        lat_lo = 2; lat_hi = 2;
        step(1'b0, 1'b0, 32'd0);
        do_reset(1);
        lat_lo = 0; lat_hi = 0;
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        chk_eq("t6_ir", ir, 32'h0050_0093);
        chk_eq("t6_pc1", pc1, RESET_PC);

        // randomized traffic, including targets that wrap past 2^32
        lat_lo = 0; lat_hi = 3;
        n_deliv = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0)
                tgt = 32'hFFFF_FFF0 + {28'd0, 2'($urandom_range(0, 3)), 2'b00};
            else
                tgt = RESET_PC + {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            if ($urandom_range(0, 499) == 0)
                do_reset($urandom_range(1, 2));
            else
                step(1'($urandom_range(0, 99) < 30), 1'($urandom_range(0, 99) < 5), tgt);
        end
        chk_eq("progress", {31'd0, (n_deliv >= 200)}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
